// File: rtl/player_motion_ctrl.sv
// Player motion controller: horizontal walk/bounce plus a jump/gravity vertical model.
// All state advances once per frame_tick; outputs are the registered state itself.
module player_motion_ctrl #(
    parameter int RANGE_X  = 624,
    parameter int RANGE_Y  = 368,
    parameter int SPEED    = 2,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       auto_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic [1:0] state,
    output logic [4:0] vel
);

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10
    } motion_state_t;

    // 11-bit copies of the position limits so sums and compares never overflow.
    localparam logic [10:0] RX_W    = 11'(RANGE_X);
    localparam logic [10:0] RY_W    = 11'(RANGE_Y);
    localparam logic [10:0] SPEED_W = 11'(SPEED);
    localparam logic [4:0]  JV      = 5'(JUMP_VEL);
    localparam logic [4:0]  GRAV    = 5'(GRAVITY);
    localparam logic [5:0]  MAX_F6  = 6'(MAX_FALL);

    motion_state_t state_q, state_d;
    logic [9:0]    px_q, px_d;
    logic [9:0]    py_q, py_d;
    logic [4:0]    vel_q, vel_d;
    logic          dir_q, dir_d;    // 1 = moving right
    logic          armed_q, armed_d;

    logic [10:0]   px_w;
    logic [10:0]   py_w;
    logic [10:0]   vel_w;
    logic [10:0]   rise_sum;
    logic [4:0]    vel_dec;
    logic [5:0]    vel_inc;

    // Registers: synchronous reset wins; otherwise load the next-state values.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GROUND;
            px_q    <= '0;
            py_q    <= '0;
            vel_q   <= '0;
            dir_q   <= 1'b1;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vel_q   <= vel_d;
            dir_q   <= dir_d;
            armed_q <= armed_d;
        end
    end

    // Next-state: horizontal and vertical motion both advance on a frame tick.
    // NOTE: every signal gets a hold default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        vel_d    = vel_q;
        dir_d    = dir_q;
        armed_d  = armed_q;
        px_w     = {1'b0, px_q};
        py_w     = {1'b0, py_q};
        vel_w    = {6'b0, vel_q};
        rise_sum = py_w + vel_w;
        vel_dec  = vel_q - GRAV;
        vel_inc  = {1'b0, vel_q} + {1'b0, GRAV};

        if (frame_tick) begin
            // Horizontal
            if (auto_mode) begin
                if (dir_q) begin
                    if (px_w >= RX_W - SPEED_W) begin
                        px_d  = RX_W[9:0];
                        dir_d = 1'b0;
                    end else begin
                        px_d = 10'(px_w + SPEED_W);
                    end
                end else begin
                    if (px_w <= SPEED_W) begin
                        px_d  = '0;
                        dir_d = 1'b1;
                    end else begin
                        px_d = 10'(px_w - SPEED_W);
                    end
                end
            end else if (btn_left && !btn_right) begin
                dir_d = 1'b0;
                px_d  = (px_w <= SPEED_W) ? 10'd0 : 10'(px_w - SPEED_W);
            end else if (btn_right && !btn_left) begin
                dir_d = 1'b1;
                px_d  = (px_w + SPEED_W >= RX_W) ? RX_W[9:0] : 10'(px_w + SPEED_W);
            end

            // Any tick with the button released re-arms the jump.
            if (!btn_jump) begin
                armed_d = 1'b1;
            end

            // Vertical
            case (state_q)
                GROUND: begin
                    py_d  = '0;
                    vel_d = '0;
                    if (btn_jump && armed_q) begin
                        state_d = RISE;
                        vel_d   = JV;
                        armed_d = 1'b0;
                    end
                end
                RISE: begin
                    py_d = (rise_sum >= RY_W) ? RY_W[9:0] : rise_sum[9:0];
                    if (vel_dec == 5'd0 || rise_sum >= RY_W) begin
                        state_d = FALL;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_dec;
                    end
                end
                FALL: begin
                    // A landing tick never starts a jump; GROUND handles that next tick.
                    if (py_w <= vel_w) begin
                        state_d = GROUND;
                        py_d    = '0;
                        vel_d   = '0;
                    end else begin
                        py_d  = 10'(py_w - vel_w);
                        vel_d = (vel_inc >= MAX_F6) ? MAX_F6[4:0] : vel_inc[4:0];
                    end
                end
                default: begin
                    state_d = GROUND;
                    py_d    = '0;
                    vel_d   = '0;
                end
            endcase
        end
    end

    // Outputs are the registers themselves.
    assign px    = px_q;
    assign py    = py_q;
    assign state = state_q;
    assign vel   = vel_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus a randomized run,
// compared every tick against a frame-level motion model.
module tb_player_motion_ctrl;

    localparam int RX   = 624;
    localparam int RY   = 368;
    localparam int SP   = 2;
    localparam int JV   = 12;
    localparam int GR   = 1;
    localparam int MF   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       auto_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] state;
    logic [4:0] vel;

    int total = 0;
    int bad   = 0;

    // Reference model: positions in plain integers, phase 0=ground 1=rise 2=fall.
    int m_px, m_py, m_vel, m_phase;
    bit m_right, m_armed;

    player_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .auto_mode  (auto_mode),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .px         (px),
        .py         (py),
        .state      (state),
        .vel        (vel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".px"},    32'(px),    32'(m_px));
        check({tag, ".py"},    32'(py),    32'(m_py));
        check({tag, ".state"}, 32'(state), 32'(m_phase));
        check({tag, ".vel"},   32'(vel),   32'(m_vel));
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_vel = 0; m_phase = 0; m_right = 1'b1; m_armed = 1'b1;
    endtask

    // One frame of the player's motion, straight from the rules of the game.
    task automatic model_frame(input bit j, input bit l, input bit r, input bit a);
        bit next_armed;
        int peak;
        if (a) begin
            if (m_right) begin
                if (m_px + SP >= RX) begin m_px = RX; m_right = 1'b0; end
                else m_px = m_px + SP;
            end else begin
                if (m_px - SP <= 0) begin m_px = 0; m_right = 1'b1; end
                else m_px = m_px - SP;
            end
        end else if (l != r) begin
            m_px    = l ? ((m_px - SP < 0) ? 0 : m_px - SP) : ((m_px + SP > RX) ? RX : m_px + SP);
            m_right = r;
        end

        next_armed = m_armed | ~j;
        if (m_phase == 0) begin
            m_py = 0;
            m_vel = 0;
            if (j && m_armed) begin m_phase = 1; m_vel = JV; next_armed = 1'b0; end
        end else if (m_phase == 1) begin
            peak = m_py + m_vel;
            m_py = (peak > RY) ? RY : peak;
            if (m_vel - GR <= 0 || peak >= RY) begin m_phase = 2; m_vel = 0; end
            else m_vel = m_vel - GR;
        end else begin
            if (m_py <= m_vel) begin m_phase = 0; m_py = 0; m_vel = 0; end
            else begin
                m_py  = m_py - m_vel;
                m_vel = (m_vel + GR > MF) ? MF : m_vel + GR;
            end
        end
        m_armed = next_armed;
    endtask

    // Idle cycles with junk on the inputs (must be ignored), then one frame tick.
    task automatic do_tick(input bit j, input bit l, input bit r, input bit a, input int idle,
                           input string tag);
        for (int i = 0; i < idle; i++) begin
            frame_tick = 1'b0;
            btn_jump   = 1'($urandom_range(0, 1));
            btn_left   = 1'($urandom_range(0, 1));
            btn_right  = 1'($urandom_range(0, 1));
            auto_mode  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        if (idle > 0) check_all({tag, ".hold"});
        btn_jump   = j;
        btn_left   = l;
        btn_right  = r;
        auto_mode  = a;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        model_frame(j, l, r, a);
        check_all(tag);
    endtask

    task automatic do_reset(input bit with_tick);
        reset      = 1'b1;
        frame_tick = with_tick;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        frame_tick = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int max_px;
        int max_py;
        int jumps;
        logic [1:0] prev_state;

        reset = 1'b1; frame_tick = 1'b0; auto_mode = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b1);

        // Auto bounce: 0,2,...,624 at tick 312, then back to 622.
        max_px = 0;
        for (int t = 1; t <= 320; t++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, 2), "auto");
            if (int'(px) > max_px) max_px = int'(px);
            if (t == 312) check("auto.px_at_312", 32'(px), 32'd624);
            if (t == 313) check("auto.px_at_313", 32'(px), 32'd622);
        end
        check("auto.max_px", 32'(max_px), 32'd624);

        // Single jump pulse: climb to 78 and come back down to the grass.
        do_reset(1'b0);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1, "jump_start");
        check("jump.vel0", 32'(vel), 32'd12);
        check("jump.state0", 32'(state), 32'd1);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 0, "jump");
        check("jump.py1", 32'(py), 32'd12);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 0, "jump");
        check("jump.py2", 32'(py), 32'd23);
        max_py = 0;
        for (int t = 0; t < 40; t++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 2), "jump");
            if (int'(py) > max_py) max_py = int'(py);
        end
        check("jump.peak", 32'(max_py), 32'd78);
        check("jump.landed", 32'(state), 32'd0);

        // Jump held across landing: exactly one jump until released.
        do_reset(1'b0);
        jumps = 0;
        prev_state = state;
        for (int t = 0; t < 60; t++) begin
            do_tick(1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 2), "held");
            if (prev_state == 2'd0 && state == 2'd1) jumps++;
            prev_state = state;
        end
        check("held.jumps", 32'(jumps), 32'd1);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 0, "held_release");
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 0, "held_repress");
        check("held.rejump", 32'(state), 32'd1);

        // Manual mode: walk to 100, both buttons hold, then saturate at RANGE_X.
        do_reset(1'b0);
        for (int t = 0; t < 50; t++) do_tick(1'b0, 1'b0, 1'b1, 1'b0, 0, "walk");
        for (int t = 0; t < 10; t++) do_tick(1'b0, 1'b1, 1'b1, 1'b0, 1, "both");
        check("both.px", 32'(px), 32'd100);
        for (int t = 0; t < 270; t++) do_tick(1'b0, 1'b0, 1'b1, 1'b0, 0, "right_sat");
        check("right_sat.px", 32'(px), 32'd624);
        for (int t = 0; t < 320; t++) do_tick(1'b0, 1'b1, 1'b0, 1'b0, 0, "left_sat");
        check("left_sat.px", 32'(px), 32'd0);

        // Reset mid-rise without a frame tick aborts the jump.
        do_reset(1'b0);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 0, "rise");
        for (int t = 0; t < 5; t++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 0, "rise");
        check("rise.py50", 32'(py), 32'd50);
        check("rise.state", 32'(state), 32'd1);
        do_reset(1'b0);
        do_tick(1'b1, 1'b0, 1'b0, 1'b0, 0, "post_reset_jump");

        // Jump toggled only between ticks: stays on the ground.
        do_reset(1'b0);
        for (int t = 0; t < 100; t++) do_tick(1'b0, 1'b0, 1'b0, 1'b0, 2, "offtick");
        check("offtick.state", 32'(state), 32'd0);

        // Randomized play against the model.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
            do_tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 3), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameter RANGE_X, 624: max px (640 minus player width 16).
REQ-002 Parameter RANGE_Y, 368: max py (grass top 384 minus player height 16).
REQ-003 Parameter SPEED, 2: horizontal pixels per frame.
REQ-004 Parameter JUMP_VEL, 12: initial upward speed, pixels/frame.
REQ-005 Parameter GRAVITY, 1: speed change per frame.
REQ-006 Parameter MAX_FALL, 15: terminal fall speed, pixels/frame.
REQ-007 clk  input  1  system clock (pixel clock); single clock domain.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 frame_tick  input  1  one-cycle strobe per frame (driven from vmax).
REQ-010 auto_mode  input  1  1 = autonomous horizontal bounce; 0 = button control.
REQ-011 btn_left  input  1  move left, level-sensitive.
REQ-012 btn_right  input  1  move right, level-sensitive.
REQ-013 btn_jump  input  1  jump request, level-sensitive.
REQ-014 px  output  10  player left edge, pixels from screen left.
REQ-015 py  output  10  player height above grass top (0 = standing on grass).
REQ-016 state  output  2  motion state: 00 GROUND, 01 RISE, 10 FALL.
REQ-017 vel  output  5  current vertical speed magnitude, unsigned.

Function
REQ-018 All state updates SHALL occur only on clock edges where frame_tick=1; on all other cycles every register holds.
REQ-019 Latency: new px/py/state/vel SHALL be visible the cycle after the frame_tick cycle; all outputs are registered.
REQ-020 Buttons and auto_mode SHALL be sampled only on frame_tick cycles; changes between ticks have no effect.
REQ-021 Horizontal, auto_mode=1: internal dir (1=right) moves px by +/-SPEED; at px >= RANGE_X-SPEED moving right, px <= RANGE_X and dir <= 0; at px <= SPEED moving left, px <= 0 and dir <= 1.
REQ-022 Horizontal, auto_mode=0: left only -> px-SPEED saturating at 0; right only -> px+SPEED saturating at RANGE_X; both or neither -> hold; dir updated to last pressed direction.
REQ-023 px SHALL never wrap and SHALL stay in [0, RANGE_X]; the same holds for py in [0, RANGE_Y].
REQ-024 Jump arming: internal armed flag clears when a jump starts and sets on any tick with btn_jump=0; holding btn_jump SHALL NOT retrigger.
REQ-025 GROUND: on tick with btn_jump=1 and armed=1 -> RISE, vel <= JUMP_VEL, py unchanged this tick; otherwise stay, py=0, vel=0.
REQ-026 RISE: py <= min(py+vel, RANGE_Y), vel <= vel-GRAVITY; if vel-GRAVITY == 0 or py+vel >= RANGE_Y -> FALL with vel <= 0.
REQ-027 FALL: if py <= vel -> py <= 0, vel <= 0, GROUND (landing); else py <= py-vel, vel <= min(vel+GRAVITY, MAX_FALL).
REQ-028 Landing tick with btn_jump=1 SHALL NOT start a jump that tick; earliest jump is the following tick, still subject to armed.
REQ-029 Horizontal and vertical motion SHALL update on the same tick, independent of state.
REQ-030 Illegal state 11 SHALL transition to GROUND with py=0, vel=0 on the next tick.
REQ-031 Arithmetic SHALL use at least 11-bit intermediates for px/py sums so saturation compares are overflow-free.

Reset
REQ-032 On reset=1 at a clock edge (regardless of frame_tick): px=0, py=0, state=GROUND, vel=0, dir=1, armed=1.
REQ-033 Reset asserted mid-jump SHALL abort the jump immediately; first tick after release behaves as from GROUND.

Verification
REQ-034 auto_mode=1, no buttons, 320 ticks -> px 0,2,4,...,624 at tick 312, then 622; px never exceeds 624.
REQ-035 GROUND, btn_jump pulsed one tick -> RISE vel=12; py 12,23,33,...,78 reached with vel reaching 0 -> FALL; py returns to 0, state=GROUND after symmetric descent; py never negative.
REQ-036 btn_jump held continuously across landing -> exactly one jump; state stays GROUND until btn_jump released one tick and re-pressed.
REQ-037 auto_mode=0, btn_left and btn_right both 1 for 10 ticks at px=100 -> px stays 100; btn_right only at px=623 -> px=624 next tick, then holds.
REQ-038 reset asserted with state=RISE, py=50, no frame_tick -> next cycle px=0, py=0, state=00, vel=0.
REQ-039 btn_jump toggled on non-tick cycles only -> no state change over 100 ticks.
